// File: rtl/sixteen_bit_mul.sv
// Unsigned 16x16->32 radix-2 shift-add multiplier, one multiplier bit per clock, LSB first.
// Latency 16 cycles accept->done; SIXTEEN_BIT_MUL_EARLY_TERM_EN ends once remaining multiplier bits are zero.
// No backpressure: start is taken only while idle, ignored while busy; s holds until the next done.
module sixteen_bit_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] e1,
  input  logic [15:0] e2,
  output logic        busy,
  output logic        done,
  output logic [31:0] s
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mcand;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic [15:0] mplier;
  logic [15:0] mplier_shr;
  logic [3:0]  cnt;
  logic        accept;
  logic        last;

  assign busy = (state == RUN);

  always_comb begin
    acc_sum    = acc;
    mplier_shr = mplier >> 1;
    accept     = 1'b0;
    last       = 1'b0;
    state_nxt  = state;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end
`ifdef SIXTEEN_BIT_MUL_EARLY_TERM_EN
    // Nothing left to add once the shifted-out multiplier is all zeros.
    last = (cnt == 4'd15) || (mplier_shr == 16'd0);
`else
    last = (cnt == 4'd15);
`endif
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= 32'd0;
      mplier <= 16'd0;
      acc    <= 32'd0;
      cnt    <= 4'd0;
      s      <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {16'd0, e1};
        mplier <= e2;
        acc    <= 32'd0;
        cnt    <= 4'd0;
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier_shr;
        cnt    <= cnt + 4'd1;
        // s only moves on the completion edge; it is the product for the rest of idle time.
        if (last) begin
          s    <= acc_sum;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sixteen_bit_mul.sv
// Self-checking bench for sixteen_bit_mul: directed and $urandom operands against a plain a*b model.
module tb_sixteen_bit_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] e1;
  logic [15:0] e2;
  logic        busy;
  logic        done;
  logic [31:0] s;

  int          n_chk;
  int          n_pass;
  logic [31:0] last_prod;

  sixteen_bit_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .e1    (e1),
    .e2    (e2),
    .busy  (busy),
    .done  (done),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int l;
`ifdef SIXTEEN_BIT_MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 16; i++) if (b[i]) l = i + 1;
`else
    l = 16;
`endif
    return l;
  endfunction

  // Called with the unit idle, #1 after an edge. Returns #1 after the done edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    int          lat;
    logic        seen;
    logic        held;
    logic [31:0] p;
    p     = 32'(a) * 32'(b);
    start = 1'b1;
    e1    = a;
    e2    = b;
    @(posedge clk); #1;
    start = 1'b0;
    e1    = 16'($urandom);
    e2    = 16'($urandom);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat  = 0;
    seen = 1'b0;
    held = (s === last_prod);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (s !== last_prod) held = 1'b0;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("s_held_during_op", 64'(held), 64'd1);
    if (seen) begin
      check("latency", 64'(lat), 64'(exp_lat(b)));
      check("product", 64'(s), 64'(p));
      check("busy_at_done", 64'(busy), 64'd0);
      last_prod = p;
    end
  endtask

  logic [15:0] da [11] = '{16'd0, 16'd1, 16'd10, 16'd255, 16'd1024, 16'd32767,
                           16'd65535, 16'd65535, 16'd10, 16'd7, 16'd3};
  logic [15:0] db [11] = '{16'd0, 16'd123, 16'd25, 16'd255, 16'd2, 16'd2,
                           16'd1, 16'd65535, 16'd25, 16'd0, 16'd65535};

  initial begin
    logic        seen;
    logic [15:0] pa;
    logic [15:0] pb;
    int          dexp;
    int          next_acc;
    int          n_done;

    n_chk     = 0;
    n_pass    = 0;
    last_prod = 32'd0;
    rst_n     = 1'b0;
    start     = 1'b0;
    e1        = 16'd0;
    e2        = 16'd0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_s", 64'(s), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    do_op(16'd7, 16'd9);
    start = 1'b1; e1 = 16'd255; e2 = 16'd255;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_s", 64'(s), 64'd0);
    last_prod = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_reset", 64'(seen), 64'd0);
    check("s_zero_after_reset", 64'(s), 64'd0);

    // Directed products, with a gap to see the one-cycle done pulse.
    for (int i = 0; i < 11; i++) begin
      do_op(da[i], db[i]);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("s_held_idle", 64'(s), 64'(last_prod));
    end

    // Back-to-back: start is raised in the cycle done is high.
    do_op(16'd300, 16'd400);
    do_op(16'd1234, 16'd4321);
    do_op(16'($urandom), 16'($urandom));

    // Randomized operands with assorted multiplier widths.
    for (int i = 0; i < 20; i++) begin
      do_op(16'($urandom), 16'($urandom) >> $urandom_range(0, 15));
    end

    // start held high while operands change each cycle.
    @(posedge clk); #1;
    start    = 1'b1;
    dexp     = -1;
    next_acc = 0;
    n_done   = 0;
    pa       = 16'd0;
    pb       = 16'd0;
    for (int k = 0; k < 80 && n_done < 3; k++) begin
      e1 = 16'($urandom);
      e2 = 16'($urandom) >> $urandom_range(0, 8);
      @(posedge clk);
      if (k == next_acc) begin
        pa       = e1;
        pb       = e2;
        dexp     = k + exp_lat(pb);
        next_acc = dexp + 1;
      end
      #1;
      check("hs_done", 64'(done), 64'(k == dexp));
      if (k == dexp) begin
        check("hs_product", 64'(s), 64'(32'(pa) * 32'(pb)));
        last_prod = 32'(pa) * 32'(pb);
        n_done++;
      end else begin
        check("hs_s_held", 64'(s), 64'(last_prod));
      end
    end
    check("hs_ops_done", 64'(n_done), 64'd3);
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
